fp_operand_align_prep: RTL and testbench

Two-stage pipelined front end of the single-precision floating-point adder. It unpacks two IEEE-754 operands, applies the add/subtract control, orders them by magnitude and computes the exponent difference. It drives the variable right-shifter directly: the shift count feeds the shifter's shift-amount input and the smaller mantissa feeds its data input. A valid/ready handshake on both sides allows stalls from the mantissa-add stage.

---
 rtl/fp_operand_align_prep_if.sv | 33 +++
 rtl/fp_operand_align_prep.sv | 172 +++++++++++++++++
 tb/tb_fp_operand_align_prep.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_operand_align_prep_if.sv
// Operand-pair / aligned-bundle bus of the FP adder front end.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1; a
// producer holding valid keeps its data stable until that edge, and ready may depend on valid.
interface fp_operand_align_prep_if;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_op_a;
    logic [31:0] i_op_b;
    logic        i_sub;

    logic        o_valid;
    logic        i_ready;
    logic [7:0]  o_num_shifts;
    logic [25:0] o_large_mant;
    logic [25:0] o_small_mant;
    logic [7:0]  o_exp;
    logic        o_sign;
    logic        o_eff_sub;
    logic        o_special;
    logic [31:0] o_special_result;

    modport slave (
        input  i_valid, i_op_a, i_op_b, i_sub, i_ready,
        output o_ready, o_valid, o_num_shifts, o_large_mant, o_small_mant,
        output o_exp, o_sign, o_eff_sub, o_special, o_special_result
    );

    modport master (
        output i_valid, i_op_a, i_op_b, i_sub, i_ready,
        input  o_ready, o_valid, o_num_shifts, o_large_mant, o_small_mant,
        input  o_exp, o_sign, o_eff_sub, o_special, o_special_result
    );
endinterface

// File: rtl/fp_operand_align_prep.sv
// Two-stage binary32 adder front end: unpack and compare, then swap, exponent difference
// and NaN/Inf decode, feeding the alignment shifter. Elastic valid/ready on both sides.
module fp_operand_align_prep (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    fp_operand_align_prep_if.slave bus
);
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [7:0]  EXP_MAX = 8'hFF;

    logic        s1_valid_q, s1_valid_d;
    logic        s1_sign_a_q, s1_sign_a_d;
    logic        s1_sign_b_q, s1_sign_b_d;
    logic [7:0]  s1_exp_a_q, s1_exp_a_d;
    logic [7:0]  s1_exp_b_q, s1_exp_b_d;
    logic [22:0] s1_frac_a_q, s1_frac_a_d;
    logic [22:0] s1_frac_b_q, s1_frac_b_d;
    logic        s1_a_large_q, s1_a_large_d;

    logic        s2_valid_q, s2_valid_d;
    logic [7:0]  s2_num_shifts_q, s2_num_shifts_d;
    logic [25:0] s2_large_mant_q, s2_large_mant_d;
    logic [25:0] s2_small_mant_q, s2_small_mant_d;
    logic [7:0]  s2_exp_q, s2_exp_d;
    logic        s2_sign_q, s2_sign_d;
    logic        s2_eff_sub_q, s2_eff_sub_d;
    logic        s2_special_q, s2_special_d;
    logic [31:0] s2_special_result_q, s2_special_result_d;

    logic s2_free, s1_free, accept, s1_move;

    assign s2_free     = !s2_valid_q || bus.i_ready;
    assign s1_free     = !s1_valid_q || s2_free;
    assign accept      = bus.i_valid && s1_free;
    assign s1_move     = s1_valid_q && s2_free;
    assign bus.o_ready = s1_free;

    always_comb begin
        s1_valid_d   = s1_free ? bus.i_valid : s1_valid_q;
        s1_sign_a_d  = s1_sign_a_q;
        s1_sign_b_d  = s1_sign_b_q;
        s1_exp_a_d   = s1_exp_a_q;
        s1_exp_b_d   = s1_exp_b_q;
        s1_frac_a_d  = s1_frac_a_q;
        s1_frac_b_d  = s1_frac_b_q;
        s1_a_large_d = s1_a_large_q;
        if (accept) begin
            s1_sign_a_d  = bus.i_op_a[31];
            s1_sign_b_d  = bus.i_op_b[31] ^ bus.i_sub;
            s1_exp_a_d   = bus.i_op_a[30:23];
            s1_exp_b_d   = bus.i_op_b[30:23];
            s1_frac_a_d  = bus.i_op_a[22:0];
            s1_frac_b_d  = bus.i_op_b[22:0];
            // Raw {exp, frac} ordering equals magnitude ordering; ties leave A as large.
            s1_a_large_d = (bus.i_op_a[30:0] >= bus.i_op_b[30:0]);
        end
    end

    logic [7:0]  eff_exp_a, eff_exp_b;
    logic [25:0] mant_a, mant_b;
    logic        nan_a, nan_b, inf_a, inf_b, eff_sub;
    logic        special;
    logic [31:0] special_result;

    always_comb begin
        eff_exp_a = (s1_exp_a_q == 8'd0) ? 8'd1 : s1_exp_a_q;
        eff_exp_b = (s1_exp_b_q == 8'd0) ? 8'd1 : s1_exp_b_q;
        mant_a    = {(s1_exp_a_q != 8'd0), s1_frac_a_q, 2'b00};
        mant_b    = {(s1_exp_b_q != 8'd0), s1_frac_b_q, 2'b00};
        nan_a     = (s1_exp_a_q == EXP_MAX) && (s1_frac_a_q != 23'd0);
        nan_b     = (s1_exp_b_q == EXP_MAX) && (s1_frac_b_q != 23'd0);
        inf_a     = (s1_exp_a_q == EXP_MAX) && (s1_frac_a_q == 23'd0);
        inf_b     = (s1_exp_b_q == EXP_MAX) && (s1_frac_b_q == 23'd0);
        eff_sub   = s1_sign_a_q ^ s1_sign_b_q;

        special        = 1'b0;
        special_result = 32'd0;
        if (nan_a || nan_b) begin
            special        = 1'b1;
            special_result = QNAN;
        end else if (inf_a && inf_b && eff_sub) begin
            special        = 1'b1;
            special_result = QNAN;
        end else if (inf_a) begin
            special        = 1'b1;
            special_result = {s1_sign_a_q, EXP_MAX, 23'd0};
        end else if (inf_b) begin
            special        = 1'b1;
            special_result = {s1_sign_b_q, EXP_MAX, 23'd0};
        end
    end

    always_comb begin
        s2_valid_d          = s2_free ? s1_valid_q : s2_valid_q;
        s2_num_shifts_d     = s2_num_shifts_q;
        s2_large_mant_d     = s2_large_mant_q;
        s2_small_mant_d     = s2_small_mant_q;
        s2_exp_d            = s2_exp_q;
        s2_sign_d           = s2_sign_q;
        s2_eff_sub_d        = s2_eff_sub_q;
        s2_special_d        = s2_special_q;
        s2_special_result_d = s2_special_result_q;
        if (s1_move) begin
            s2_eff_sub_d        = eff_sub;
            s2_special_d        = special;
            s2_special_result_d = special_result;
            if (s1_a_large_q) begin
                s2_num_shifts_d = eff_exp_a - eff_exp_b;
                s2_large_mant_d = mant_a;
                s2_small_mant_d = mant_b;
                s2_exp_d        = eff_exp_a;
                s2_sign_d       = s1_sign_a_q;
            end else begin
                s2_num_shifts_d = eff_exp_b - eff_exp_a;
                s2_large_mant_d = mant_b;
                s2_small_mant_d = mant_a;
                s2_exp_d        = eff_exp_b;
                s2_sign_d       = s1_sign_b_q;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s1_valid_q          <= 1'b0;
            s1_sign_a_q         <= 1'b0;
            s1_sign_b_q         <= 1'b0;
            s1_exp_a_q          <= 8'd0;
            s1_exp_b_q          <= 8'd0;
            s1_frac_a_q         <= 23'd0;
            s1_frac_b_q         <= 23'd0;
            s1_a_large_q        <= 1'b0;
            s2_valid_q          <= 1'b0;
            s2_num_shifts_q     <= 8'd0;
            s2_large_mant_q     <= 26'd0;
            s2_small_mant_q     <= 26'd0;
            s2_exp_q            <= 8'd0;
            s2_sign_q           <= 1'b0;
            s2_eff_sub_q        <= 1'b0;
            s2_special_q        <= 1'b0;
            s2_special_result_q <= 32'd0;
        end else begin
            s1_valid_q          <= s1_valid_d;
            s1_sign_a_q         <= s1_sign_a_d;
            s1_sign_b_q         <= s1_sign_b_d;
            s1_exp_a_q          <= s1_exp_a_d;
            s1_exp_b_q          <= s1_exp_b_d;
            s1_frac_a_q         <= s1_frac_a_d;
            s1_frac_b_q         <= s1_frac_b_d;
            s1_a_large_q        <= s1_a_large_d;
            s2_valid_q          <= s2_valid_d;
            s2_num_shifts_q     <= s2_num_shifts_d;
            s2_large_mant_q     <= s2_large_mant_d;
            s2_small_mant_q     <= s2_small_mant_d;
            s2_exp_q            <= s2_exp_d;
            s2_sign_q           <= s2_sign_d;
            s2_eff_sub_q        <= s2_eff_sub_d;
            s2_special_q        <= s2_special_d;
            s2_special_result_q <= s2_special_result_d;
        end
    end

    assign bus.o_valid          = s2_valid_q;
    assign bus.o_num_shifts     = s2_num_shifts_q;
    assign bus.o_large_mant     = s2_large_mant_q;
    assign bus.o_small_mant     = s2_small_mant_q;
    assign bus.o_exp            = s2_exp_q;
    assign bus.o_sign           = s2_sign_q;
    assign bus.o_eff_sub        = s2_eff_sub_q;
    assign bus.o_special        = s2_special_q;
    assign bus.o_special_result = s2_special_result_q;
endmodule

// File: tb/tb_fp_operand_align_prep.sv
// Bench for fp_operand_align_prep: directed vector table, back-pressure and reset
// sequences, and a randomized stream scored against an arithmetic reference model.
module tb_fp_operand_align_prep;
    localparam int W = 103;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] prev_bundle;
    logic         prev_stall = 1'b0;

    fp_operand_align_prep_if bus ();

    fp_operand_align_prep dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]  a;
        logic [31:0]  b;
        logic         sub;
        logic [W-1:0] exp;
    } vec_t;

    vec_t vecs[9];

    function automatic logic [W-1:0] pack(input logic [7:0] sh, input logic [25:0] lm,
                                          input logic [25:0] sm, input logic [7:0] ex,
                                          input logic sg, input logic es, input logic sp,
                                          input logic [31:0] res);
        return {sh, lm, sm, ex, sg, es, sp, res};
    endfunction

    function automatic logic [W-1:0] dut_bundle();
        return {bus.o_num_shifts, bus.o_large_mant, bus.o_small_mant, bus.o_exp,
                bus.o_sign, bus.o_eff_sub, bus.o_special, bus.o_special_result};
    endfunction

    // Reference model: magnitudes and mantissas as plain integers.
    function automatic logic [W-1:0] model(input logic [31:0] a, input logic [31:0] b,
                                           input logic s);
        int unsigned ea, eb, fa, fb, eea, eeb, ma, mb, shifts, lm, sm, lex;
        bit sa, sb, a_big, nan_a, nan_b, inf_a, inf_b, eff, sp, sg;
        logic [31:0] res;
        ea = a[30:23]; eb = b[30:23];
        fa = a[22:0];  fb = b[22:0];
        sa = a[31];    sb = b[31] ^ s;
        a_big = (ea > eb) || (ea == eb && fa >= fb);
        eea = (ea == 0) ? 1 : ea;
        eeb = (eb == 0) ? 1 : eb;
        ma = ((ea != 0) ? (1 << 25) : 0) + fa * 4;
        mb = ((eb != 0) ? (1 << 25) : 0) + fb * 4;
        nan_a = (ea == 255) && (fa != 0);
        nan_b = (eb == 255) && (fb != 0);
        inf_a = (ea == 255) && (fa == 0);
        inf_b = (eb == 255) && (fb == 0);
        eff = (sa != sb);
        sp = 1; res = 32'h0;
        if (nan_a || nan_b)               res = QNAN;
        else if (inf_a && inf_b && eff)   res = QNAN;
        else if (inf_a)                   res = {sa, 31'h7F80_0000};
        else if (inf_b)                   res = {sb, 31'h7F80_0000};
        else                              sp = 0;
        if (a_big) begin
            shifts = eea - eeb; lm = ma; sm = mb; lex = eea; sg = sa;
        end else begin
            shifts = eeb - eea; lm = mb; sm = ma; lex = eeb; sg = sb;
        end
        return pack(8'(shifts), 26'(lm), 26'(sm), 8'(lex), sg, eff, sp, res);
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic check_int(input string name, input int act, input int expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Driver: present a pair, wait (bounded) for acceptance; returns just after the accepting edge.
    task automatic drive_pair(input logic [31:0] a, input logic [31:0] b, input logic s);
        int t;
        t = 0;
        bus.i_valid = 1'b1;
        bus.i_op_a  = a;
        bus.i_op_b  = b;
        bus.i_sub   = s;
        @(negedge clk);
        while (!bus.o_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check_int("accept_wait", int'(bus.o_ready), 1);
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
    endtask

    function automatic logic [31:0] rand_op();
        logic [7:0]  e;
        logic [22:0] f;
        int c;
        c = $urandom_range(0, 9);
        case (c)
            0:       e = 8'd0;
            1:       e = 8'd255;
            2, 3:    e = 8'($urandom_range(120, 130));
            default: e = 8'($urandom_range(0, 255));
        endcase
        f = 23'($urandom);
        if (c == 1 && $urandom_range(0, 1) == 1) f = 23'd0;
        return {1'($urandom_range(0, 1)), e, f};
    endfunction

    // Scoreboard / monitor, sampling at the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (bus.o_valid && prev_stall) check("stall_hold", dut_bundle(), prev_bundle);
            if (bus.o_valid && bus.i_ready) begin
                if (exp_q.size() == 0) check_int("unexpected_bundle", int'(bus.o_valid), 0);
                else check("scoreboard", dut_bundle(), exp_q.pop_front());
            end
            prev_stall  = bus.o_valid && !bus.i_ready;
            prev_bundle = dut_bundle();
            if (bus.i_valid && bus.o_ready) exp_q.push_back(model(bus.i_op_a, bus.i_op_b, bus.i_sub));
        end
    end

    initial begin : main
        int lat;
        int bp_accepted;
        bit rand_done;
        logic [31:0] ra, rb;

        vecs[0] = '{32'h3F80_0000, 32'h4000_0000, 1'b0, pack(8'd1,   26'h200_0000, 26'h200_0000, 8'h80, 0, 0, 0, 32'h0)};
        vecs[1] = '{32'h4040_0000, 32'h4040_0000, 1'b1, pack(8'd0,   26'h300_0000, 26'h300_0000, 8'h80, 0, 1, 0, 32'h0)};
        vecs[2] = '{32'h4B00_0000, 32'h0000_0001, 1'b0, pack(8'd149, 26'h200_0000, 26'h000_0004, 8'd150, 0, 0, 0, 32'h0)};
        vecs[3] = '{32'h7F80_0000, 32'hFF80_0000, 1'b0, pack(8'd0,   26'h200_0000, 26'h200_0000, 8'hFF, 0, 1, 1, QNAN)};
        vecs[4] = '{32'h7FC0_0001, 32'h3F80_0000, 1'b0, pack(8'd128, 26'h300_0004, 26'h200_0000, 8'hFF, 0, 0, 1, QNAN)};
        vecs[5] = '{32'h7F80_0000, 32'h3F80_0000, 1'b1, pack(8'd128, 26'h200_0000, 26'h200_0000, 8'hFF, 0, 1, 1, 32'h7F80_0000)};
        vecs[6] = '{32'h3F80_0000, 32'h7F80_0000, 1'b1, pack(8'd128, 26'h200_0000, 26'h200_0000, 8'hFF, 1, 1, 1, 32'hFF80_0000)};
        vecs[7] = '{32'h0000_0003, 32'h8000_0001, 1'b0, pack(8'd0,   26'h000_000C, 26'h000_0004, 8'd1,  0, 1, 0, 32'h0)};
        vecs[8] = '{32'h0000_0000, 32'h0000_0000, 1'b1, pack(8'd0,   26'h000_0000, 26'h000_0000, 8'd1,  0, 1, 0, 32'h0)};

        // Clock / reset
        rst_n = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_op_a  = 32'h0;
        bus.i_op_b  = 32'h0;
        bus.i_sub   = 1'b0;
        bus.i_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_int("reset_valid", int'(bus.o_valid), 0);
        check("reset_outputs", dut_bundle(), '0);
        rst_n = 1'b1;
        check_int("reset_ready", int'(bus.o_ready), 1);

        // Directed vector table, one pair at a time with latency check
        for (int i = 0; i < 9; i++) begin
            bus.i_valid = 1'b1;
            bus.i_op_a  = vecs[i].a;
            bus.i_op_b  = vecs[i].b;
            bus.i_sub   = vecs[i].sub;
            @(posedge clk);
            #1;
            bus.i_valid = 1'b0;
            lat = 1;
            while (!bus.o_valid && lat < 10) begin
                @(posedge clk);
                #1;
                lat++;
            end
            check_int($sformatf("latency%0d", i), lat, 2);
            check($sformatf("vec%0d", i), dut_bundle(), vecs[i].exp);
            @(posedge clk);
            #1;
        end

        // Back-pressure: four pairs against a 5-cycle stall
        bus.i_ready = 1'b0;
        bp_accepted = 0;
        fork
            begin
                for (int k = 0; k < 4; k++) begin
                    drive_pair(32'h3F80_0000 + 32'(k << 20), 32'h4000_0000 + 32'(k), 1'(k & 1));
                    bp_accepted++;
                end
            end
            begin
                repeat (5) @(negedge clk);
                check_int("bp_ready_low", int'(bus.o_ready), 0);
                check_int("bp_held", bp_accepted, 2);
                @(posedge clk);
                #1;
                bus.i_ready = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    check_int($sformatf("bp_stream%0d", k), int'(bus.o_valid), 1);
                end
                @(negedge clk);
                check_int("bp_done", int'(bus.o_valid), 0);
            end
        join
        @(posedge clk);
        #1;

        // Reset with both stages full
        bus.i_ready = 1'b0;
        drive_pair(32'h4120_0000, 32'h3F00_0000, 1'b0);
        drive_pair(32'hC120_0000, 32'h4000_0000, 1'b1);
        check_int("full_ready_low", int'(bus.o_ready), 0);
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        check_int("midrst_valid", int'(bus.o_valid), 0);
        check("midrst_outputs", dut_bundle(), '0);
        rst_n = 1'b1;
        bus.i_ready = 1'b1;
        @(posedge clk);
        #1;
        check_int("midrst_ready", int'(bus.o_ready), 1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check_int("no_stale", int'(bus.o_valid), 0);
        end
        @(posedge clk);
        #1;

        // Randomized stream with random downstream stalls
        rand_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 300; k++) begin
                    ra = rand_op();
                    rb = ($urandom_range(0, 7) == 0) ? ra : rand_op();
                    drive_pair(ra, rb, 1'($urandom_range(0, 1)));
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    bus.i_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        bus.i_ready = 1'b1;
        lat = 0;
        while (exp_q.size() != 0 && lat < 50) begin
            @(posedge clk);
            lat++;
        end
        check_int("drain", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
